// File: rtl/bram_seq_reader_pkg.sv
// Shared types and sizing helpers for the sequential BRAM reader.
package bram_seq_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int FIFO_DEPTH = 2;

  // One extra bit so a full-memory run (2^ADDR_WIDTH words) fits in the length field.
  function automatic int len_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/seq_reader_fifo2.sv
// Two-entry synchronous FIFO; push and pop in the same cycle are both honoured.
module seq_reader_fifo2
  import bram_seq_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head = mem[rd_ptr];

  // Read issue is credit-limited upstream, so these can only fire on a logic bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count == 2'(FIFO_DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && count == 2'd0));

endmodule

// File: rtl/bram_seq_reader.sv
// Streams a contiguous run of words from a 1-cycle read-latency BRAM onto a valid/ready stream.
// Optional SEQ_READER_REVERSE_EN adds a 'reverse' input that walks the run in descending order.
module bram_seq_reader
  import bram_seq_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = len_width(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef SEQ_READER_REVERSE_EN
  ,
  input  logic                  reverse
`endif
);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] first_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  inflight;
  logic [1:0]            fifo_count;
  logic [2:0]            occupancy;
  logic                  pop;
  logic                  issue;
  logic                  dir_rev;
  logic                  accept;

  assign accept = (state == IDLE) && start;
  assign pop    = out_valid && out_ready;

  // Words already buffered plus the one in the BRAM pipe, less the one leaving now.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == READ) && (remaining != '0) && (occupancy < 3'(FIFO_DEPTH));

`ifdef SEQ_READER_REVERSE_EN
  logic                  rev_q;
  logic [ADDR_WIDTH-1:0] len_lo;

  assign len_lo     = length[ADDR_WIDTH-1:0];
  assign first_addr = reverse ? (start_addr + len_lo - ADDR_WIDTH'(1)) : start_addr;
  assign dir_rev    = rev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rev_q <= 1'b0;
    end else if (accept) begin
      rev_q <= reverse;
    end
  end
`else
  assign first_addr = start_addr;
  assign dir_rev    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = (length == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issue && (remaining == LEN_WIDTH'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Leave once the pipe is empty and the last buffered word is handed off this cycle.
        if (!inflight && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (accept) begin
        cur_addr  <= first_addr;
        remaining <= length;
      end else if (issue) begin
        cur_addr  <= dir_rev ? (cur_addr - ADDR_WIDTH'(1)) : (cur_addr + ADDR_WIDTH'(1));
        remaining <= remaining - LEN_WIDTH'(1);
      end
    end
  end

  // Address is held between issues; the extra BRAM reads it causes are never captured.
  assign bram_addr = cur_addr;

  seq_reader_fifo2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight),
    .push_data(bram_data),
    .pop      (pop),
    .head     (out_data),
    .count    (fifo_count)
  );

  assign out_valid = (fifo_count != 2'd0);

endmodule
